exe_muldiv_sequencer: RTL and testbench

Multi-cycle sequencer for unsigned multiply and divide in the EXE stage. Accepts an operation from the instruction currently in EXE and iterates a shift-add multiplier or restoring divider over WIDTH cycles. Stalls the pipeline while iterating, then publishes the result into HI/LO registers. Sits beside the single-cycle ALU and shares its operand inputs (readdata1 → dataa, data2 → datab).

---
 rtl/exe_muldiv_sequencer.sv | 118 +++++++++++
 tb/tb_exe_muldiv_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/exe_muldiv_sequencer.sv
// Multi-cycle unsigned MULTU/DIVU sequencer for the EXE stage: shift-add multiply or
// restoring divide over WIDTH cycles, stalling the pipeline, then committing HI/LO.
module exe_muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic             flush,
   input  logic [WIDTH-1:0] dataa,
   input  logic [WIDTH-1:0] datab,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero,
   output logic [1:0]       state_dbg
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] operand;
   logic [WIDTH-1:0] acc_hi, acc_lo;
   logic [WIDTH-1:0] acc_hi_nxt, acc_lo_nxt;
   logic [WIDTH:0]   mul_sum, div_shift, div_diff;
   logic             accept, last_iter;

   assign last_iter = (cnt == '0);

   // acc_lo holds the multiplier (MUL) or dividend/quotient (DIV); acc_hi is the
   // upper product half or the partial remainder.
   always_comb begin
      mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
      div_shift  = {acc_hi, acc_lo[WIDTH-1]};
      div_diff   = div_shift - {1'b0, operand};
      acc_hi_nxt = acc_hi;
      acc_lo_nxt = acc_lo;
      if (state == S_MUL) begin
         acc_hi_nxt = mul_sum[WIDTH:1];
         acc_lo_nxt = {mul_sum[0], acc_lo[WIDTH-1:1]};
      end else if (state == S_DIV) begin
         // Remainder stays below the divisor, so the MSB of the W+1-bit difference is the borrow.
         if (div_diff[WIDTH]) begin
            acc_hi_nxt = div_shift[WIDTH-1:0];
            acc_lo_nxt = {acc_lo[WIDTH-2:0], 1'b0};
         end else begin
            acc_hi_nxt = div_diff[WIDTH-1:0];
            acc_lo_nxt = {acc_lo[WIDTH-2:0], 1'b1};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (accept) state_nxt = op[0] ? S_DIV : S_MUL;
         S_MUL, S_DIV: begin
            if (flush)          state_nxt = S_IDLE;
            else if (last_iter) state_nxt = S_DONE;
         end
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      accept    = (state == S_IDLE) && start && !op[1] && !flush;
      stall     = accept || (state == S_MUL) || (state == S_DIV);
      busy      = (state != S_IDLE);
      done      = (state == S_DONE);
      state_dbg = state;
   end

   // Result registers only move on entry to DONE; a flush leaves them untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt         <= '0;
         operand     <= '0;
         acc_hi      <= '0;
         acc_lo      <= '0;
         hi          <= '0;
         lo          <= '0;
         div_by_zero <= 1'b0;
      end else if (accept) begin
         cnt         <= CW'(WIDTH - 1);
         operand     <= datab;
         acc_hi      <= '0;
         acc_lo      <= dataa;
         div_by_zero <= 1'b0;
      end else if ((state == S_MUL || state == S_DIV) && !flush) begin
         acc_hi <= acc_hi_nxt;
         acc_lo <= acc_lo_nxt;
         cnt    <= cnt - 1'b1;
         if (last_iter) begin
            hi <= acc_hi_nxt;
            lo <= acc_lo_nxt;
            if (state == S_DIV) div_by_zero <= (operand == '0);
         end
      end
   end

endmodule

// File: tb/tb_exe_muldiv_sequencer.sv
// Self-checking bench for exe_muldiv_sequencer: scoreboard of {div_by_zero, hi, lo}
// results plus latency, stall, flush, reset and invalid-op scenarios.
module tb_exe_muldiv_sequencer;

   localparam int W = 32;

   logic         clk, rst, start, flush;
   logic [1:0]   op;
   logic [W-1:0] dataa, datab;
   logic         stall, busy, done, div_by_zero;
   logic [W-1:0] hi, lo;
   logic [1:0]   state_dbg;

   logic [2*W:0] exp_q[$];
   int           n_checks = 0;
   int           n_errors = 0;

   exe_muldiv_sequencer #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .flush(flush),
      .dataa(dataa), .datab(datab), .stall(stall), .busy(busy), .done(done),
      .hi(hi), .lo(lo), .div_by_zero(div_by_zero), .state_dbg(state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2*W:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-1:0] prod;
      if (o == 2'b00) begin
         prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
         return {1'b0, prod};
      end
      if (b == '0) return {1'b1, a, {W{1'b1}}};
      return {1'b0, a % b, a / b};
   endfunction

   // Hold start until stall drops, then compare the popped result when done fires.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      int cyc, stall_n;
      bit got;
      logic [2*W:0] e;
      @(negedge clk);
      start = 1'b1; op = o; dataa = a; datab = b;
      exp_q.push_back(model(o, a, b));
      cyc = 0; stall_n = 0; got = 0;
      while (!got && cyc < 100) begin
         #1;
         if (stall) stall_n++;
         if (done) got = 1;
         else begin
            @(negedge clk);
            cyc++;
         end
      end
      check({tag, " done_seen"}, 64'(got), 64'd1);
      check({tag, " latency"}, 64'(cyc), 64'(W + 1));
      check({tag, " stall_cycles"}, 64'(stall_n), 64'(W + 1));
      check({tag, " busy_in_done"}, 64'(busy), 64'd1);
      e = exp_q.pop_front();
      check({tag, " hi"}, 64'(hi), 64'(e[2*W-1:W]));
      check({tag, " lo"}, 64'(lo), 64'(e[W-1:0]));
      check({tag, " div_by_zero"}, 64'(div_by_zero), 64'(e[2*W]));
      start = 1'b0;
      @(negedge clk); #1;
      check({tag, " done_pulse_once"}, 64'(done), 64'd0);
      check({tag, " idle_after"}, 64'({busy, stall}), 64'd0);
      check({tag, " hi_hold"}, 64'(hi), 64'(e[2*W-1:W]));
   endtask

   task automatic watch_no_done(input string tag, input int ncyc, input logic [W-1:0] hi_e, input logic [W-1:0] lo_e);
      int seen;
      seen = 0;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk); #1;
         if (done || busy || stall) seen++;
      end
      check({tag, " no_activity"}, 64'(seen), 64'd0);
      check({tag, " hi_kept"}, 64'(hi), 64'(hi_e));
      check({tag, " lo_kept"}, 64'(lo), 64'(lo_e));
   endtask

   initial begin
      logic [W-1:0] hi_prev, lo_prev;
      rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; dataa = '0; datab = '0;
      repeat (3) @(negedge clk);
      #1;
      check("reset outputs", 64'({stall, busy, done, div_by_zero}), 64'd0);
      check("reset hi", 64'(hi), 64'd0);
      check("reset lo", 64'(lo), 64'd0);
      check("reset state", 64'(state_dbg), 64'd0);
      rst = 1'b0;

      run_op("mul7x6", 2'b00, 32'd7, 32'd6);
      run_op("mul_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op("div100_7", 2'b01, 32'd100, 32'd7);
      run_op("div_max_16", 2'b01, 32'hFFFF_FFFF, 32'h10);
      run_op("div5_0", 2'b01, 32'd5, 32'd0);
      run_op("mul2x3", 2'b00, 32'd2, 32'd3);
      for (int i = 0; i < 4; i++) begin
         logic [1:0] o;
         logic [W-1:0] a, b;
         o = 2'($urandom_range(0, 1));
         a = $urandom();
         b = (i == 3) ? 32'($urandom_range(1, 255)) : $urandom();
         run_op($sformatf("rand%0d", i), o, a, b);
      end

      // Flush a MULTU at its tenth iteration.
      hi_prev = hi; lo_prev = lo;
      @(negedge clk);
      start = 1'b1; op = 2'b00; dataa = 32'd1234; datab = 32'd5678;
      repeat (10) @(negedge clk);
      #1;
      check("flush pre busy", 64'(busy), 64'd1);
      start = 1'b0; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("flush stall", 64'(stall), 64'd0);
      check("flush state", 64'(state_dbg), 64'd0);
      watch_no_done("flush", 40, hi_prev, lo_prev);

      // Invalid opcode is ignored.
      @(negedge clk);
      start = 1'b1; op = 2'b10; dataa = 32'd9; datab = 32'd3;
      #1;
      check("invalid stall", 64'(stall), 64'd0);
      watch_no_done("invalid", 5, hi_prev, lo_prev);
      start = 1'b0;

      // Start together with flush in IDLE.
      @(negedge clk);
      start = 1'b1; op = 2'b01; flush = 1'b1;
      #1;
      check("start_flush stall", 64'(stall), 64'd0);
      watch_no_done("start_flush", 5, hi_prev, lo_prev);
      start = 1'b0; flush = 1'b0;

      // Reset in the middle of a DIVU.
      @(negedge clk);
      start = 1'b1; op = 2'b01; dataa = 32'd1000; datab = 32'd3;
      repeat (12) @(negedge clk);
      start = 1'b0;
      rst = 1'b1;
      #1;
      check("midrst hi", 64'(hi), 64'd0);
      check("midrst lo", 64'(lo), 64'd0);
      check("midrst flags", 64'({stall, busy, done, div_by_zero}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      watch_no_done("midrst", 40, '0, '0);

      check("queue drained", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
